// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the two-wide fetch buffer.
// Instruction payloads are stored beside the entry so INSTR_WIDTH stays a module parameter.
package fetch_buffer_pkg;

    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned FETCH_PAIR        = 2;
    localparam int unsigned FETCH_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [FETCH_PAIR-1:0][ADDR_WIDTH-1:0] pc;
        logic [FETCH_PAIR-1:0]                 valid;
        logic [FETCH_PAIR-1:0]                 pred_branch;
        logic                                  filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_kill_counter.sv
// Tracks outstanding imem requests and how many upcoming responses belong to
// work killed by a flush and must be dropped.
module fetch_kill_counter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic req_fire,
    input  logic rsp_valid,
    output logic drop_c
);

    // Headroom for several back-to-back flushes with requests still in flight
    localparam int unsigned CW = $clog2(DEPTH) + 3;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] kill_cnt;
    logic [CW-1:0] kill_nxt;

    // A flush marks every request still unanswered after this cycle as stale
    always_comb begin
        outstanding_nxt = outstanding;
        kill_nxt        = kill_cnt;
        if (req_fire) begin
            outstanding_nxt = outstanding_nxt + CW'(1);
        end
        if (rsp_valid && (outstanding != '0)) begin
            outstanding_nxt = outstanding_nxt - CW'(1);
        end
        if (flush) begin
            kill_nxt = outstanding_nxt;
        end else if (rsp_valid && (kill_cnt != '0)) begin
            kill_nxt = kill_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            kill_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            kill_cnt    <= kill_nxt;
        end
    end

    assign drop_c = (kill_cnt != '0);

endmodule

// File: rtl/fetch_buffer.sv
// Two-wide fetch buffer: one imem request per predicted PC pair, in-order queue, pair handoff to decode.
// Define FETCH_BUF_BYPASS_EN to forward a response straight to decode when it completes the head entry.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [FETCH_PAIR-1:0][ADDR_WIDTH-1:0]   guess,
    input  logic [FETCH_PAIR-1:0]                   guess_valid,
    input  logic [FETCH_PAIR-1:0]                   guesses_branch,
    output logic                                    fetch_stall,
    output logic                                    imem_req_valid,
    output logic [ADDR_WIDTH-1:0]                   imem_req_addr,
    input  logic                                    imem_req_ready,
    input  logic                                    imem_rsp_valid,
    input  logic [FETCH_PAIR*INSTR_WIDTH-1:0]       imem_rsp_data,
    output logic [FETCH_PAIR-1:0]                   dec_valid,
    output logic [FETCH_PAIR-1:0][ADDR_WIDTH-1:0]   dec_pc,
    output logic [FETCH_PAIR-1:0][INSTR_WIDTH-1:0]  dec_instr,
    output logic [FETCH_PAIR-1:0]                   dec_pred_branch,
    input  logic                                    dec_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t                          meta    [DEPTH];
    logic [FETCH_PAIR*INSTR_WIDTH-1:0]     instr_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fill_ptr;
    logic [CW-1:0] count;

    logic full;
    logic req_fire;
    logic drop;
    logic fill;
    logic bypass_hit;
    logic head_ready;
    logic pop;

    fetch_kill_counter #(
        .DEPTH (DEPTH)
    ) u_kill (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_fire  (req_fire),
        .rsp_valid (imem_rsp_valid),
        .drop_c    (drop)
    );

    assign full           = (count == CW'(DEPTH));
    assign imem_req_valid = guess_valid[0] & ~full & ~flush;
    assign imem_req_addr  = guess[0];
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign fetch_stall    = full | ~imem_req_ready | flush;
    assign fill           = imem_rsp_valid & ~drop & ~flush;

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass_hit = fill & (count != '0) & ~meta[head].filled & (fill_ptr == head);
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_ready      = (count != '0) & (meta[head].filled | bypass_hit);
    assign pop             = dec_ready & head_ready & ~flush;
    assign dec_valid       = {FETCH_PAIR{head_ready}} & meta[head].valid;
    assign dec_pc          = meta[head].pc;
    assign dec_pred_branch = meta[head].pred_branch;
    assign dec_instr       = bypass_hit ? imem_rsp_data : instr_q[head];

    // Queue bookkeeping; a flush collapses every pointer onto the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                meta[i] <= '0;
            end
        end else if (flush) begin
            count    <= '0;
            head     <= tail;
            fill_ptr <= tail;
        end else begin
            if (fill && !(bypass_hit && pop)) begin
                meta[fill_ptr].filled <= 1'b1;
            end
            if (fill) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (req_fire) begin
                meta[tail] <= '{pc: guess, valid: guess_valid,
                                pred_branch: guesses_branch, filled: 1'b0};
                tail       <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({req_fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Instruction payload storage carries no reset; validity lives in meta
    always_ff @(posedge clk) begin
        if (fill) begin
            instr_q[fill_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed guesses, a fixed-latency memory model,
// and a decoupled monitor comparing each decode handshake against queued expectations.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 32;
    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int          LAT   = 2;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic [1:0][AW-1:0]   guess;
    logic [1:0]           guess_valid;
    logic [1:0]           guesses_branch;
    logic                 fetch_stall;
    logic                 imem_req_valid;
    logic [AW-1:0]        imem_req_addr;
    logic                 imem_req_ready;
    logic                 imem_rsp_valid;
    logic [2*IW-1:0]      imem_rsp_data;
    logic [1:0]           dec_valid;
    logic [1:0][AW-1:0]   dec_pc;
    logic [1:0][IW-1:0]   dec_instr;
    logic [1:0]           dec_pred_branch;
    logic                 dec_ready;

    fetch_buffer #(.DEPTH(DEPTH), .INSTR_WIDTH(IW)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .guess           (guess),
        .guess_valid     (guess_valid),
        .guesses_branch  (guesses_branch),
        .fetch_stall     (fetch_stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_instr       (dec_instr),
        .dec_pred_branch (dec_pred_branch),
        .dec_ready       (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] pc0, pc1;
        logic [IW-1:0] i0, i1;
        logic          v0, v1, b0, b1;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;
    mreq_t mq[$];
    logic  mem_hold = 1'b0;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return {32'h00100093, 32'h00000013};
        return {32'hB000_0000 | (a + 32'd4), 32'hA000_0000 | a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory: fixed latency, in order, at most one response per cycle
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && !mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (reset) mq.delete();
            else if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + LAT});
        end
    end

    // Monitor: every decode handshake pops and checks one expected pair
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && dec_ready && (dec_valid != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dec_unexpected: actual pc=%0h required none", dec_pc[0]);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_valid", 64'(dec_valid), 64'({e.v1, e.v0}));
                    if (e.v0) begin
                        chk("dec_pc0", 64'(dec_pc[0]), 64'(e.pc0));
                        chk("dec_instr0", 64'(dec_instr[0]), 64'(e.i0));
                        chk("dec_br0", 64'(dec_pred_branch[0]), 64'(e.b0));
                    end
                    if (e.v1) begin
                        chk("dec_pc1", 64'(dec_pc[1]), 64'(e.pc1));
                        chk("dec_instr1", 64'(dec_instr[1]), 64'(e.i1));
                        chk("dec_br1", 64'(dec_pred_branch[1]), 64'(e.b1));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        guess_valid    = 2'b00;
        guesses_branch = 2'b00;
    endtask

    task automatic set_guess(input logic [AW-1:0] pc, input logic v1, input logic b0, input logic b1);
        guess[0]       = pc;
        guess[1]       = pc + AW'(4);
        guess_valid    = {v1, 1'b1};
        guesses_branch = {b1, b0};
    endtask

    // Drive one guess pair and check whether it is requested this cycle
    task automatic issue(input logic [AW-1:0] pc, input logic v1, input logic b0,
                         input logic b1, input logic acc);
        exp_t        e;
        logic [63:0] w;
        set_guess(pc, v1, b0, b1);
        settle();
        chk("req_valid", 64'(imem_req_valid), 64'(acc));
        chk("fetch_stall", 64'(fetch_stall), 64'(!acc));
        if (acc) begin
            chk("req_addr", 64'(imem_req_addr), 64'(pc));
            w     = mem_word(pc);
            e.pc0 = pc;
            e.pc1 = pc + AW'(4);
            e.i0  = w[31:0];
            e.i1  = w[63:32];
            e.v0  = 1'b1;
            e.v1  = v1;
            e.b0  = b0;
            e.b1  = v1 & b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc_start();
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (3) cyc_start();
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        guess          = '0;
        guess_valid    = 2'b00;
        guesses_branch = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);

        // Basic pair: request in cycle 0, response in cycle 2
        cyc_start();
        reset     = 1'b0;
        dec_ready = 1'b1;
        issue(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); idle(); settle();
        chk("lat_c1_valid", 64'(dec_valid), 64'd0);
        cyc_start(); settle();
`ifdef FETCH_BUF_BYPASS_EN
        chk("lat_c2_valid", 64'(dec_valid), 64'd3);
`else
        chk("lat_c2_valid", 64'(dec_valid), 64'd0);
        cyc_start(); settle();
        chk("lat_c3_valid", 64'(dec_valid), 64'd3);
`endif
        chk("lat_stall", 64'(fetch_stall), 64'd0);
        wait_drain("drain_basic");

        // Fill the queue under back-pressure, then free exactly one slot
        dec_ready = 1'b0;
        issue(32'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h18, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h28, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc_start(); issue(32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc_start();
        dec_ready = 1'b1;
        issue(32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_start();
        dec_ready = 1'b0;
        issue(32'h30, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h38, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_start(); idle();
        dec_ready = 1'b1;
        wait_drain("drain_full");

        // Flush with two requests in flight
        mem_hold = 1'b1;
        cyc_start(); issue(32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h48, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start();
        flush = 1'b1;
        exp_q.delete();
        set_guess(32'h50, 1'b1, 1'b0, 1'b0);
        settle();
        chk("flush_req_valid", 64'(imem_req_valid), 64'd0);
        chk("flush_stall", 64'(fetch_stall), 64'd1);
        cyc_start();
        flush    = 1'b0;
        mem_hold = 1'b0;
        issue(32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush2_kill", 64'(dut.u_kill.kill_cnt), 64'd2);
        chk("flush2_count", 64'(dut.count), 64'd0);
        cyc_start(); idle();
        wait_drain("drain_flush2");
        chk("flush2_kill_end", 64'(dut.u_kill.kill_cnt), 64'd0);

        // Flush coinciding with a response and a guess
        issue(32'h60, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h68, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start();
        flush = 1'b1;
        exp_q.delete();
        set_guess(32'h70, 1'b1, 1'b0, 1'b0);
        settle();
        chk("flushrsp_req_valid", 64'(imem_req_valid), 64'd0);
        cyc_start();
        flush = 1'b0;
        idle();
        settle();
        chk("flushrsp_count", 64'(dut.count), 64'd0);
        chk("flushrsp_kill", 64'(dut.u_kill.kill_cnt), 64'd1);
        chk("flushrsp_dec_valid", 64'(dec_valid), 64'd0);
        cyc_start();
        issue(32'h200, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flushrsp_kill_done", 64'(dut.u_kill.kill_cnt), 64'd0);
        cyc_start(); idle();
        wait_drain("drain_flushrsp");

        // Partial pair and branch flags
        issue(32'h8, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc_start(); issue(32'hC0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc_start(); idle();
        wait_drain("drain_partial");

        // Reset with three held entries and one response still to kill
        dec_ready = 1'b0;
        mem_hold  = 1'b1;
        issue(32'h300, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start();
        flush = 1'b1;
        exp_q.delete();
        idle();
        cyc_start();
        flush = 1'b0;
        issue(32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h408, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); issue(32'h410, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); idle(); settle();
        chk("pre_rst_count", 64'(dut.count), 64'd3);
        chk("pre_rst_kill", 64'(dut.u_kill.kill_cnt), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("mid_rst_stall", 64'(fetch_stall), 64'd0);
        chk("mid_rst_count", 64'(dut.count), 64'd0);
        chk("mid_rst_kill", 64'(dut.u_kill.kill_cnt), 64'd0);
        chk("mid_rst_tail", 64'(dut.tail), 64'd0);
        mem_hold = 1'b0;
        cyc_start();
        reset     = 1'b0;
        dec_ready = 1'b1;
        issue(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_start(); idle();
        wait_drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
